mem_stage_sram_ctrl: RTL and testbench

Memory-access engine for the MEM stage. It sits between the EXE/MEM pipeline register and MEM_Stage_reg. It turns one 32-bit load or store into two sequential 16-bit accesses on the off-chip SRAM. It drives superStall (superStall = ~ready) so the whole pipeline, including MEM_Stage_reg, freezes until the access completes. The read word feeds MEM_Stage_reg.Mem_Data_in.

---
 rtl/mem_stage_sram_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// Splits one 32-bit load/store into two 16-bit SRAM half-accesses of ACCESS_CYCLES each.
// Stalls 2*ACCESS_CYCLES+1 cycles (ready=0), then ready=1 for one DONE cycle; requests must be held while ready=0.
module mem_stage_sram_ctrl #(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] DATA_BASE     = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_En,
    input  logic        MEM_W_En,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        req, last;
    logic [31:0] off;
    logic [16:0] word;
    logic        dq_drv;
    logic [15:0] dq_dat;
    logic        unused_off;

    assign req        = MEM_R_En | MEM_W_En;
    assign last       = (cnt == LAST);
    assign off        = address - DATA_BASE;
    assign word       = off[18:2];
    assign unused_off = ^{off[31:19], off[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A simultaneous read and write request is serviced as a write.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = MEM_W_En ? WR_LO : RD_LO;
                    cnt_nxt   = '0;
                end
            end
            RD_LO, RD_HI, WR_LO, WR_HI: begin
                if (last) begin
                    cnt_nxt = '0;
                    case (state)
                        RD_LO:   state_nxt = RD_HI;
                        WR_LO:   state_nxt = WR_HI;
                        default: state_nxt = DONE;
                    endcase
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready     = ~req | (state == DONE);
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_drv    = 1'b0;
        dq_dat    = '0;
        case (state)
            RD_LO: SRAM_ADDR = {word, 1'b0};
            RD_HI: SRAM_ADDR = {word, 1'b1};
            WR_LO: begin
                SRAM_ADDR = {word, 1'b0};
                SRAM_WE_N = 1'b0;
                dq_drv    = 1'b1;
                dq_dat    = wdata[15:0];
            end
            WR_HI: begin
                SRAM_ADDR = {word, 1'b1};
                SRAM_WE_N = 1'b0;
                dq_drv    = 1'b1;
                dq_dat    = wdata[31:16];
            end
            default: ;
        endcase
    end

    assign SRAM_DQ   = dq_drv ? dq_dat : 16'bz;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // Each half is captured on the final cycle its address is held, when the SRAM output has settled longest.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (state == RD_LO && last) begin
            rdata[15:0] <= SRAM_DQ;
        end else if (state == RD_HI && last) begin
            rdata[31:16] <= SRAM_DQ;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
module tb_mem_stage_sram_ctrl;

    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en, w_en;
    logic [31:0] addr, wd;
    logic        sel;

    always #5 clk = ~clk;

    // Two DUTs: a has ACCESS_CYCLES=2, b has ACCESS_CYCLES=1; only the selected one sees requests.
    logic        r_a, w_a, r_b, w_b;
    assign r_a = r_en & ~sel;
    assign w_a = w_en & ~sel;
    assign r_b = r_en & sel;
    assign w_b = w_en & sel;

    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, we_n_a, we_n_b;
    logic [17:0] sa_a, sa_b;
    logic        oe_a, ce_a, ub_a, lb_a, oe_b, ce_b, ub_b, lb_b;
    wire  [15:0] dq_a, dq_b;

    mem_stage_sram_ctrl #(.ACCESS_CYCLES(2), .DATA_BASE(32'd1024)) dut_a (
        .clk(clk), .rst(rst), .MEM_R_En(r_a), .MEM_W_En(w_a), .address(addr), .wdata(wd),
        .rdata(rdata_a), .ready(ready_a), .SRAM_ADDR(sa_a), .SRAM_DQ(dq_a), .SRAM_WE_N(we_n_a),
        .SRAM_OE_N(oe_a), .SRAM_CE_N(ce_a), .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a));

    mem_stage_sram_ctrl #(.ACCESS_CYCLES(1), .DATA_BASE(32'd1024)) dut_b (
        .clk(clk), .rst(rst), .MEM_R_En(r_b), .MEM_W_En(w_b), .address(addr), .wdata(wd),
        .rdata(rdata_b), .ready(ready_b), .SRAM_ADDR(sa_b), .SRAM_DQ(dq_b), .SRAM_WE_N(we_n_b),
        .SRAM_OE_N(oe_b), .SRAM_CE_N(ce_b), .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b));

    // SRAM models: drive the bus whenever not being written, latch writes on the clock.
    logic [15:0] mem_a [0:262143];
    logic [15:0] mem_b [0:262143];
    bit          mem_ready = 1'b0;

    assign dq_a = we_n_a ? mem_a[sa_a] : 16'bz;
    assign dq_b = we_n_b ? mem_b[sa_b] : 16'bz;

    function automatic logic [15:0] init_half(input logic [17:0] h);
        return h[15:0] ^ {6'b0, h[17:8]} ^ 16'hA5C3;
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 262144; i++) begin
                mem_a[i] <= init_half(18'(i));
                mem_b[i] <= init_half(18'(i));
            end
            mem_ready <= 1'b1;
        end else begin
            if (!we_n_a) mem_a[sa_a] <= dq_a;
            if (!we_n_b) mem_b[sa_b] <= dq_b;
        end
    end

    wire [31:0] rdata_s = sel ? rdata_b : rdata_a;
    wire        ready_s = sel ? ready_b : ready_a;
    wire [17:0] sa_s    = sel ? sa_b : sa_a;
    wire        we_s    = sel ? we_n_b : we_n_a;
    wire [15:0] dq_s    = sel ? dq_b : dq_a;
    wire [3:0]  ties_s  = sel ? {oe_b, ce_b, ub_b, lb_b} : {oe_a, ce_a, ub_a, lb_a};

    // Reference model: word-level store history per DUT, plus last loaded word per DUT.
    logic [31:0] stored [logic [17:0]];
    logic [31:0] rdata_ref [2];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [16:0] word_idx(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return o[18:2];
    endfunction

    function automatic logic [31:0] word_of(input logic s, input logic [16:0] w);
        if (stored.exists({s, w})) return stored[{s, w}];
        return {init_half({w, 1'b1}), init_half({w, 1'b0})};
    endfunction

    function automatic logic [15:0] half_of(input logic s, input logic [17:0] h);
        logic [31:0] x;
        x = word_of(s, h[17:1]);
        return h[0] ? x[31:16] : x[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT idle; checks every cycle of one access (or one idle cycle).
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int abort_at);
        int          ac = sel ? 1 : 2;
        int          n  = 2 * ac + 2;
        bit          req = rd | wr;
        logic [16:0] w  = word_idx(a);
        logic [31:0] wexp;
        logic [17:0] ea;
        logic [15:0] edq;
        bit          lo, hi, ewe;
        wexp = wr ? d : word_of(sel, w);
        r_en = rd; w_en = wr; addr = a; wd = d;
        if (!req) begin
            #1;
            chk("idle_ready", 32'(ready_s), 32'd1);
            chk("idle_we_n", 32'(we_s), 32'd1);
            chk("idle_addr", 32'(sa_s), 32'd0);
            chk("idle_dq", 32'(dq_s), 32'(half_of(sel, 18'd0)));
            chk("idle_rdata", rdata_s, rdata_ref[sel]);
            @(negedge clk);
            return;
        end
        for (int c = 0; c < n; c++) begin
            #1;
            lo  = (c >= 1) && (c <= ac);
            hi  = (c > ac) && (c <= 2 * ac);
            ea  = lo ? {w, 1'b0} : (hi ? {w, 1'b1} : 18'd0);
            ewe = !((lo || hi) && wr);
            edq = !ewe ? (hi ? d[31:16] : d[15:0]) : half_of(sel, ea);
            chk("ready", 32'(ready_s), 32'(c == n - 1));
            chk("sram_addr", 32'(sa_s), 32'(ea));
            chk("we_n", 32'(we_s), 32'(ewe));
            chk("dq", 32'(dq_s), 32'(edq));
            if (c == 0) chk("rdata_hold", rdata_s, rdata_ref[sel]);
            if (c == n - 1) begin
                if (!wr) rdata_ref[sel] = wexp;
                chk("rdata_done", rdata_s, rdata_ref[sel]);
            end
            if (c == abort_at) begin
                rst = 1'b0;
                @(negedge clk);
                #1;
                rdata_ref[0] = '0;
                rdata_ref[1] = '0;
                chk("abort_addr", 32'(sa_s), 32'd0);
                chk("abort_we_n", 32'(we_s), 32'd1);
                chk("abort_rdata", rdata_s, 32'd0);
                chk("abort_ready", 32'(ready_s), 32'd0);
                rst = 1'b1;
                return;
            end
            @(negedge clk);
        end
        if (wr) stored[{sel, w}] = d;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{0, 1, 32'd1028, 32'hDEADBEEF, 32'h00000000};
        tbl[1] = '{1, 0, 32'd1028, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1, 1, 32'd1032, 32'h12345678, 32'hDEADBEEF};
        tbl[3] = '{1, 0, 32'd1032, 32'h0,        32'h12345678};
        tbl[4] = '{1, 0, 32'd1024, 32'h0,        32'hA5C2A5C3};
        tbl[5] = '{0, 1, 32'd1020, 32'hCAFEF00D, 32'hA5C2A5C3};
        tbl[6] = '{1, 0, 32'd1022, 32'h0,        32'hCAFEF00D};
        tbl[7] = '{0, 0, 32'd0,    32'h0,        32'hCAFEF00D};

        sel = 1'b0; rst = 1'b0; r_en = 1'b1; w_en = 1'b0; addr = BASE; wd = '0;
        rdata_ref[0] = '0;
        rdata_ref[1] = '0;

        // Reset held with a pending load.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_rdata", rdata_s, 32'd0);
            chk("rst_we_n", 32'(we_s), 32'd1);
            chk("rst_addr", 32'(sa_s), 32'd0);
            chk("rst_ready", 32'(ready_s), 32'd0);
            chk("rst_dq", 32'(dq_s), 32'(half_of(1'b0, 18'd0)));
            chk("rst_ties", 32'(ties_s), 32'd0);
        end
        r_en = 1'b0;
        rst  = 1'b1;

        for (int i = 0; i < 10; i++) access(0, 0, 32'd0, 32'd0, -1);

        for (int i = 0; i < 8; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, -1);
            chk($sformatf("tbl%0d_rdata", i), rdata_s, tbl[i].exp_rdata);
        end

        // Back-to-back: request stays high across the single DONE cycle.
        access(1, 0, 32'd1024, 32'd0, -1);
        access(0, 1, 32'd1032, 32'h0BADCAFE, -1);
        access(1, 0, 32'd1032, 32'd0, -1);

        // Reset during RD_HI, then a clean load.
        access(1, 0, 32'd1028, 32'd0, 3);
        access(1, 0, 32'd1028, 32'd0, -1);
        chk("post_abort_load", rdata_s, 32'hDEADBEEF);

        sel = 1'b1;
        access(0, 1, 32'd2048, 32'h13579BDF, -1);
        access(1, 0, 32'd2048, 32'd0, -1);
        access(1, 0, 32'd2048, 32'd0, 2);
        access(1, 0, 32'd2048, 32'd0, -1);
        chk("ac1_load", rdata_s, 32'h13579BDF);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            int          op;
            sel = 1'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                ra = BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            else
                ra = $urandom;
            access(op[0], op[1], ra, $urandom, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
